// File: rtl/bus_pkg.sv
// Shared types and constants for the CPU/OAM-DMA memory bus arbiter.
// Optional START delay is enabled with the DMA_START_DELAY_EN macro.
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      READ,
      WRITE
   } dma_state_t;

   localparam logic [15:0] DMA_REG_ADDR   = 16'hFF46;
   localparam logic [15:0] OAM_BASE       = 16'hFE00;
   localparam logic [15:0] IO_BASE        = 16'hFF00;
   localparam logic [7:0]  ECHO_BASE_PAGE = 8'hE0;
   localparam logic [7:0]  BLOCKED_RDATA  = 8'hFF;
   localparam int          START_DELAY    = 4;

   // Pages E0-FF mirror C0-DF (echo RAM)
   function automatic logic [7:0] src_page(input logic [7:0] src);
      return (src >= ECHO_BASE_PAGE) ? (src - 8'h20) : src;
   endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA engine: copies OAM_LEN bytes from page {src,00} to 0xFE00.
// DMA_START_DELAY_EN stretches START to START_DELAY clocks.
module oam_dma_engine
   import bus_pkg::*;
#(
   parameter int OAM_LEN = 160
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        trigger_i,
   input  logic [7:0]  trig_data_i,
   input  logic        stall_i,
   input  logic [7:0]  mem_rdata_i,
   output logic        req_read_o,
   output logic        req_write_o,
   output logic [15:0] addr_o,
   output logic [7:0]  wdata_o,
   output logic        active_o,
   output logic        done_o,
   output logic [7:0]  src_o
);

   localparam logic [7:0] LAST_IDX = 8'(OAM_LEN - 1);

   dma_state_t state_q, state_d;
   logic [7:0] count_q, count_d;
   logic [7:0] buf_q, buf_d;
   logic [7:0] src_q, src_d;
   logic       done_q, done_d;
`ifdef DMA_START_DELAY_EN
   logic [2:0] dly_q, dly_d;
`endif

   // Engine state, byte counter, data buffer and source page
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         count_q <= '0;
         buf_q   <= '0;
         src_q   <= '0;
         done_q  <= 1'b0;
`ifdef DMA_START_DELAY_EN
         dly_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         buf_q   <= buf_d;
         src_q   <= src_d;
         done_q  <= done_d;
`ifdef DMA_START_DELAY_EN
         dly_q   <= dly_d;
`endif
      end
   end

   // Next state and DMA bus request; a stall holds READ/WRITE in place
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      buf_d       = buf_q;
      src_d       = src_q;
      done_d      = 1'b0;
`ifdef DMA_START_DELAY_EN
      dly_d       = dly_q;
`endif
      req_read_o  = 1'b0;
      req_write_o = 1'b0;
      addr_o      = '0;
      wdata_o     = '0;
      unique case (state_q)
         IDLE: ;
         START: begin
`ifdef DMA_START_DELAY_EN
            if (dly_q == 3'(START_DELAY - 1)) state_d = READ;
            else dly_d = dly_q + 3'd1;
`else
            state_d = READ;
`endif
         end
         READ: begin
            if (!stall_i) begin
               req_read_o = 1'b1;
               addr_o     = {src_page(src_q), count_q};
               buf_d      = mem_rdata_i;
               state_d    = WRITE;
            end
         end
         WRITE: begin
            if (!stall_i) begin
               req_write_o = 1'b1;
               addr_o      = OAM_BASE + {8'h00, count_q};
               wdata_o     = buf_q;
               if (count_q == LAST_IDX) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  count_d = count_q + 8'd1;
                  state_d = READ;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (trigger_i) begin
         src_d   = trig_data_i;
         count_d = '0;
         state_d = START;
         done_d  = 1'b0;
`ifdef DMA_START_DELAY_EN
         dly_d   = '0;
`endif
      end
   end

   assign active_o = (state_q != IDLE);
   assign done_o   = done_q;
   assign src_o    = src_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// CPU / OAM-DMA arbiter in front of a single-port memory.
// Optional DMA start delay: define DMA_START_DELAY_EN.
module mem_bus_arbiter
   import bus_pkg::*;
#(
   parameter int OAM_LEN = 160
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req_read,
   input  logic        cpu_req_write,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic [7:0]  cpu_rdata,
   output logic        mem_req_read,
   output logic        mem_req_write,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic        dma_active,
   output logic        dma_done
);

   logic        cpu_wr, cpu_rd, cpu_any;
   logic        hit_reg, hit_io;
   logic        trigger, stall, cpu_pass;
   logic        dma_rd, dma_wr;
   logic [15:0] dma_addr;
   logic [7:0]  dma_wdata, dma_src;

   assign cpu_wr   = cpu_req_write;
   assign cpu_rd   = cpu_req_read & ~cpu_req_write;
   assign cpu_any  = cpu_req_read | cpu_req_write;
   assign hit_reg  = (cpu_addr == DMA_REG_ADDR);
   assign hit_io   = (cpu_addr >= IO_BASE);
   assign trigger  = cpu_wr & hit_reg;
   assign stall    = dma_active & cpu_any & hit_io;
   assign cpu_pass = cpu_any & ~hit_reg & (~dma_active | hit_io);

   oam_dma_engine #(
      .OAM_LEN(OAM_LEN)
   ) u_dma (
      .clk        (clk),
      .rst_n      (reset),
      .trigger_i  (trigger),
      .trig_data_i(cpu_wdata),
      .stall_i    (stall),
      .mem_rdata_i(mem_rdata),
      .req_read_o (dma_rd),
      .req_write_o(dma_wr),
      .addr_o     (dma_addr),
      .wdata_o    (dma_wdata),
      .active_o   (dma_active),
      .done_o     (dma_done),
      .src_o      (dma_src)
   );

   // Bus owner mux; the bus is forced quiet while reset is held
   always_comb begin
      mem_req_read  = 1'b0;
      mem_req_write = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      unique case (1'b1)
         !reset: ;
         reset && cpu_pass: begin
            mem_req_read  = cpu_rd;
            mem_req_write = cpu_wr;
            mem_addr      = cpu_addr;
            mem_wdata     = cpu_wr ? cpu_wdata : 8'h00;
         end
         default: begin
            mem_req_read  = dma_rd;
            mem_req_write = dma_wr;
            mem_addr      = dma_addr;
            mem_wdata     = dma_wdata;
         end
      endcase
   end

   // CPU read data: DMA register, blocked space, or memory
   always_comb begin
      cpu_rdata = mem_rdata;
      unique case (1'b1)
         hit_reg:               cpu_rdata = dma_src;
         dma_active && !hit_io: cpu_rdata = BLOCKED_RDATA;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter with a behavioural 64 KiB memory.
// Expected writes/reads are queued by stimulus and popped by a monitor.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cpu_req_read = 1'b0;
   logic        cpu_req_write = 1'b0;
   logic [15:0] cpu_addr = '0;
   logic [7:0]  cpu_wdata = '0;
   logic [7:0]  cpu_rdata;
   logic        mem_req_read, mem_req_write;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;
   logic        dma_active, dma_done;

   logic [7:0] mem [0:65535];

   typedef struct packed {
      logic [15:0] a;
      logic [7:0]  d;
   } wr_t;

   wr_t        cpu_wq[$];
   wr_t        dma_q[$];
   logic [7:0] rd_q[$];

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   int cyc = 0;
   int t_trig = 0;

   mem_bus_arbiter dut (
      .clk          (clk),
      .reset        (reset),
      .cpu_req_read (cpu_req_read),
      .cpu_req_write(cpu_req_write),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_rdata    (cpu_rdata),
      .mem_req_read (mem_req_read),
      .mem_req_write(mem_req_write),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .dma_active   (dma_active),
      .dma_done     (dma_done)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_req_write) mem[mem_addr] <= mem_wdata;
      cyc <= cyc + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic miss(input string name, input int act);
      checks++;
      errors++;
      $display("FAIL %s: got %0h expected nothing", name, act);
   endtask

   // Monitor: compare every bus write and CPU read against the queues
   always @(negedge clk) begin
      wr_t w;
      if (dma_done) done_cnt++;
      if (mem_req_write) begin
         if (mem_addr >= 16'hFE00 && mem_addr <= 16'hFE9F) begin
            if (dma_q.size() == 0) miss("dma_unexp_wr", mem_addr);
            else begin
               w = dma_q.pop_front();
               chk("dma_wr_addr", mem_addr, w.a);
               chk("dma_wr_data", mem_wdata, w.d);
            end
         end else begin
            if (cpu_wq.size() == 0) miss("cpu_unexp_wr", mem_addr);
            else begin
               w = cpu_wq.pop_front();
               chk("cpu_wr_addr", mem_addr, w.a);
               chk("cpu_wr_data", mem_wdata, w.d);
            end
         end
      end
      if (cpu_req_read && !cpu_req_write) begin
         if (rd_q.size() == 0) miss("cpu_unexp_rd", cpu_addr);
         else chk("cpu_rdata", cpu_rdata, rd_q.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d,
                         input bit fwd);
      if (fwd) cpu_wq.push_back(wr_t'{a, d});
      cpu_addr      = a;
      cpu_wdata     = d;
      cpu_req_write = 1'b1;
      tick();
      cpu_req_write = 1'b0;
      if (a == 16'hFF46) t_trig = cyc;
   endtask

   task automatic cpu_rd(input logic [15:0] a, input logic [7:0] exp);
      rd_q.push_back(exp);
      cpu_addr     = a;
      cpu_req_read = 1'b1;
      tick();
      cpu_req_read = 1'b0;
   endtask

   task automatic preload(input logic [7:0] page, input logic [7:0] x);
      for (int i = 0; i < 160; i++)
         cpu_wr({page, 8'(i)}, 8'(i) ^ x, 1'b1);
   endtask

   task automatic exp_dma(input logic [7:0] x, input int n);
      for (int i = 0; i < n; i++)
         dma_q.push_back(wr_t'{16'hFE00 + 16'(i), 8'(i) ^ x});
   endtask

   task automatic wait_dma(input string name, input int exp_dur);
      int n;
      n = 0;
      while (dma_active && n < 2000) begin
         tick();
         n++;
      end
      chk(name, cyc - t_trig, exp_dur);
   endtask

   task automatic check_oam(input int split, input logic [7:0] xlo,
                            input logic [7:0] xhi);
      for (int i = 0; i < 160; i++)
         cpu_rd(16'hFE00 + 16'(i), 8'(i) ^ ((i < split) ? xlo : xhi));
   endtask

   initial begin
      int n;
      #1;
      chk("rst_active", dma_active, 0);
      chk("rst_done", dma_done, 0);
      chk("rst_mem_rd", mem_req_read, 0);
      chk("rst_mem_wr", mem_req_write, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      #22;
      reset = 1'b1;
      tick();
      cpu_rd(16'hFF46, 8'h00);

      // 1: idle pass-through, write wins over read
      cpu_wr(16'hC000, 8'h5A, 1'b1);
      cpu_rd(16'hC000, 8'h5A);
      cpu_wq.push_back(wr_t'{16'hC020, 8'h33});
      cpu_addr      = 16'hC020;
      cpu_wdata     = 8'h33;
      cpu_req_read  = 1'b1;
      cpu_req_write = 1'b1;
      tick();
      cpu_req_read  = 1'b0;
      cpu_req_write = 1'b0;
      cpu_rd(16'hC020, 8'h33);
      chk("t1_active", dma_active, 0);

      // 2: full DMA
      preload(8'hC0, 8'hA5);
      cpu_wr(16'hD000, 8'h22, 1'b1);
      preload(8'hC1, 8'h3C);
      exp_dma(8'hA5, 160);
      done_cnt = 0;
      cpu_wr(16'hFF46, 8'hC0, 1'b0);
      wait_dma("t2_dur", 321);
      idle(2);
      chk("t2_done_cnt", done_cnt, 1);
      cpu_rd(16'hFF46, 8'hC0);
      check_oam(160, 8'hA5, 8'hA5);

      // 3: blocking of non-I/O space
      exp_dma(8'hA5, 160);
      done_cnt = 0;
      cpu_wr(16'hFF46, 8'hC0, 1'b0);
      idle(5);
      cpu_rd(16'hC010, 8'hFF);
      cpu_wr(16'hD000, 8'h11, 1'b0);
      wait_dma("t3_dur", 321);
      idle(2);
      chk("t3_done_cnt", done_cnt, 1);
      cpu_rd(16'hD000, 8'h22);

      // 4: HRAM priority stalls the DMA
      exp_dma(8'hA5, 160);
      cpu_wr(16'hFF46, 8'hC0, 1'b0);
      idle(10);
      for (int i = 0; i < 3; i++) cpu_wr(16'hFF90, 8'h77, 1'b1);
      wait_dma("t4_dur", 324);
      idle(2);
      cpu_rd(16'hFF90, 8'h77);
      cpu_rd(16'hFE00, 8'hA5);
      cpu_rd(16'hFE9F, 8'h3A);

      // 5: restart with echo-mapped source
      exp_dma(8'hA5, 24);
      done_cnt = 0;
      cpu_wr(16'hFF46, 8'hC0, 1'b0);
      idle(50);
      exp_dma(8'h3C, 160);
      cpu_wr(16'hFF46, 8'hE1, 1'b0);
      wait_dma("t5_dur", 321);
      idle(2);
      chk("t5_done_cnt", done_cnt, 1);
      cpu_rd(16'hFF46, 8'hE1);
      check_oam(160, 8'h3C, 8'h3C);

      // 6: async reset in the middle of the copy
      exp_dma(8'hA5, 80);
      cpu_wr(16'hFF46, 8'hC0, 1'b0);
      n = 0;
      while (!(mem_req_write && mem_addr == 16'hFE50) && n < 400) begin
         tick();
         n++;
      end
      chk("t6_reach_80", int'(n < 400), 1);
      reset = 1'b0;
      #1;
      chk("t6_rst_active", dma_active, 0);
      chk("t6_rst_mem_rd", mem_req_read, 0);
      chk("t6_rst_mem_wr", mem_req_write, 0);
      chk("t6_dma_left", dma_q.size(), 0);
      #2;
      reset = 1'b1;
      tick();
      idle(5);
      chk("t6_active", dma_active, 0);
      cpu_rd(16'hFF46, 8'h00);
      check_oam(80, 8'hA5, 8'h3C);

      idle(2);
      chk("end_cpu_wq", cpu_wq.size(), 0);
      chk("end_dma_q", dma_q.size(), 0);
      chk("end_rd_q", rd_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
